decode_writeback: RTL
=====================

// Module: decode_writeback
// PURPOSE
//  SEQ decode/write-back stage: the other end of the execute interface. Holds the 15x64 Y86-64
//  register file and the condition-code register. Drives valA/valB and zf_in/of_in/sf_in into
//  execute. Captures valE/valM and zf_out/of_out/sf_out back on the clock edge.
//  Sits between fetch (icode/ifun/rA/rB) and execute; memory supplies valM.
// PARAMETERS
//  WIDTH    64    datapath width of registers and valA/valB/valE/valM
//  NREGS    15    architectural registers, ids 0..14
//  RSP_ID   4'h4  stack-pointer register id
//  RNONE    4'hF  "no register" id
// PORTS
//  clk      in   1      clock; all state updates on posedge
//  rst      in   1      synchronous, active-high reset
//  icode    in   4      instruction code from fetch
//  ifun     in   4      function code; informational only, not used for write gating
//  rA       in   4      register specifier A
//  rB       in   4      register specifier B
//  halt     in   1      1 = processor not AOK; suppress all register and CC writes
//  Cnd      in   1      condition result from execute; gates cmovXX
//  valE     in   WIDTH  execute result
//  valM     in   WIDTH  memory read result
//  zf_out   in   1      new ZF from execute
//  of_out   in   1      new OF from execute
//  sf_out   in   1      new SF from execute
//  valA     out  WIDTH  operand A to execute; combinational
//  valB     out  WIDTH  operand B to execute; combinational
//  zf_in    out  1      registered ZF to execute
//  of_in    out  1      registered OF to execute
//  sf_in    out  1      registered SF to execute
//  dbg_sel  in   4      debug read select
//  dbg_val  out  WIDTH  R[dbg_sel]; 0 when dbg_sel == RNONE
// BEHAVIOUR
//  Sources (combinational):
//  - srcA = rA for icode 2, 4, 6, A; RSP for 9, B; else RNONE.
//  - srcB = rB for icode 4, 5, 6; RSP for 8, 9, A, B; else RNONE.
//  - valA = R[srcA], valB = R[srcB]; a RNONE source reads 0.
//  Destinations:
//  - dstE = rB for icode 3 and 6; rB for icode 2 only when Cnd = 1; RSP for 8, 9, A, B; else RNONE.
//  - dstM = rA for icode 5 and B; else RNONE.
//  Write rules (posedge clk, rst = 0, halt = 0):
//  - R[dstE] <= valE and R[dstM] <= valM. Writes to RNONE are dropped.
//  - dstE == dstM (popq %rsp): valM wins.
//  - Reads in the same cycle see pre-edge contents. No internal bypass: SEQ semantics, latency 1 edge.
//  CC: at posedge with icode == 6, halt = 0, rst = 0: {zf_in, sf_in, of_in} <= {zf_out, sf_out, of_out}.
//  Otherwise CC holds.
//  Reset (sync): all R = 0; zf_in = 1, sf_in = 0, of_in = 0. Hence valA = valB = dbg_val = 0 after reset.
//  - rst overrides halt and any pending write in the same cycle, including mid-instruction.
//  halt = 1: register file and CC frozen; valA/valB still track icode/rA/rB.
//  Undefined icode (> B): no sources, no destinations, no CC update.
// STRUCTURE
//  y86_pkg: icode constants (IHALT..IPOPQ), RSP_ID, RNONE, WIDTH.
//  Sub-module regfile_15x64: 2 async read ports, 2 sync write ports with port-M priority, sync reset.
//  Top level holds src/dst decode, CC register and halt gating.
// TESTING
//  1 Reset: rst = 1 for 1 cycle -> every dbg_sel 0..14 reads 0; zf_in = 1, sf_in = 0, of_in = 0;
//    valA = valB = 0.
//  2 irmovq (icode 3, rB = 2, valE = 25) -> after edge dbg_val[2] = 25; other registers unchanged.
//  3 OPq (icode 6, rA = 2, rB = 3) with R2 = 5, R3 = 10 -> valA = 5, valB = 10.
//    Edge with valE = 15, zf_out = 0, sf_out = 1, of_out = 1 -> R3 = 15; zf_in = 0, sf_in = 1, of_in = 1.
//  4 cmovle (icode 2, ifun 1, rA = 2, rB = 5): Cnd = 0 -> R5 unchanged; Cnd = 1, valE = 5 -> R5 = 5.
//    CC unchanged in both cases.
//  5 popq %rsp (icode B, rA = 4), valE = 0x108, valM = 0x55 -> R4 = 0x55.
//    Also call (icode 8, valE = 0xF8) -> R4 = 0xF8, valB = old R4 before the edge.
//  6 halt = 1 with irmovq to R7 and OPq -> R7 and CC unchanged.
//    Then rst = 1 together with an irmovq write -> all registers 0, ZF = 1.

Source files
------------

// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions for the decode/write-back slice.
// Contents:
//   - Datapath width and register file geometry.
//   - Special register ids: stack pointer and "no register".
//   - Instruction code enumeration (IHALT..IPOPQ).
package y86_pkg;

    localparam int          Y86_WIDTH = 64;
    localparam int          Y86_NREGS = 15;
    localparam logic [3:0]  Y86_RSP   = 4'h4;
    localparam logic [3:0]  Y86_RNONE = 4'hF;

    typedef enum logic [3:0] {
        IHALT   = 4'h0,
        INOP    = 4'h1,
        IRRMOVQ = 4'h2,   // also cmovXX, gated by Cnd
        IIRMOVQ = 4'h3,
        IRMMOVQ = 4'h4,
        IMRMOVQ = 4'h5,
        IOPQ    = 4'h6,
        IJXX    = 4'h7,
        ICALL   = 4'h8,
        IRET    = 4'h9,
        IPUSHQ  = 4'hA,
        IPOPQ   = 4'hB
    } icode_e;

endpackage

// File: rtl/regfile_15x64.sv
// Y86-64 architectural register file.
// Ports:
//   clk, rst              clock, synchronous active-high reset (clears every register)
//   ra_addr_i/ra_data_o   asynchronous read port A
//   rb_addr_i/rb_data_o   asynchronous read port B
//   dbg_addr_i/dbg_data_o asynchronous debug read port
//   wr_en_i               global write enable for both write ports
//   dst_e_i/val_e_i       write port E
//   dst_m_i/val_m_i       write port M (wins when both ports target the same register)
// Reading id RNONE returns zero; writing id RNONE is dropped.
module regfile_15x64 #(
    parameter int         WIDTH = 64,
    parameter int         NREGS = 15,
    parameter logic [3:0] RNONE = 4'hF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       ra_addr_i,
    input  logic [3:0]       rb_addr_i,
    input  logic [3:0]       dbg_addr_i,
    output logic [WIDTH-1:0] ra_data_o,
    output logic [WIDTH-1:0] rb_data_o,
    output logic [WIDTH-1:0] dbg_data_o,
    input  logic             wr_en_i,
    input  logic [3:0]       dst_e_i,
    input  logic [WIDTH-1:0] val_e_i,
    input  logic [3:0]       dst_m_i,
    input  logic [WIDTH-1:0] val_m_i
);

    logic [WIDTH-1:0] regs [NREGS];

    // One register per generate block; each block owns its own state so
    // every array element has exactly one driver.
    generate
        for (genvar gi = 0; gi < NREGS; gi++) begin : g_reg
            localparam logic [3:0] ID = 4'(gi);
            logic [WIDTH-1:0] reg_q;
            logic [WIDTH-1:0] reg_d;

            always_comb begin
                reg_d = reg_q;
                if (wr_en_i) begin
                    // Port M is checked first so popq %rsp keeps the popped value.
                    if (dst_m_i == ID) begin
                        reg_d = val_m_i;
                    end else if (dst_e_i == ID) begin
                        reg_d = val_e_i;
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    reg_q <= '0;
                end else begin
                    reg_q <= reg_d;
                end
            end

            assign regs[gi] = reg_q;
        end
    endgenerate

    assign ra_data_o  = (ra_addr_i  == RNONE) ? '0 : regs[ra_addr_i];
    assign rb_data_o  = (rb_addr_i  == RNONE) ? '0 : regs[rb_addr_i];
    assign dbg_data_o = (dbg_addr_i == RNONE) ? '0 : regs[dbg_addr_i];

endmodule

// File: rtl/decode_writeback.sv
// SEQ decode / write-back stage for Y86-64.
// Decodes source and destination register ids from icode/rA/rB, supplies
// valA/valB combinationally to execute, writes valE/valM back on the clock
// edge and holds the condition codes.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   icode, ifun, rA, rB      instruction fields from fetch (ifun is not used)
//   halt                     freeze register file and CC when set
//   Cnd                      execute condition, gates cmovXX write-back
//   valE, valM               execute and memory results to write back
//   zf_out, of_out, sf_out   new flags from execute (taken for OPq only)
//   valA, valB               operands to execute (combinational)
//   zf_in, of_in, sf_in      registered condition codes to execute
//   dbg_sel, dbg_val         debug register read (RNONE reads 0)
module decode_writeback
    import y86_pkg::*;
#(
    parameter int         WIDTH  = Y86_WIDTH,
    parameter int         NREGS  = Y86_NREGS,
    parameter logic [3:0] RSP_ID = Y86_RSP,
    parameter logic [3:0] RNONE  = Y86_RNONE
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       icode,
    input  logic [3:0]       ifun,
    input  logic [3:0]       rA,
    input  logic [3:0]       rB,
    input  logic             halt,
    input  logic             Cnd,
    input  logic [WIDTH-1:0] valE,
    input  logic [WIDTH-1:0] valM,
    input  logic             zf_out,
    input  logic             of_out,
    input  logic             sf_out,
    output logic [WIDTH-1:0] valA,
    output logic [WIDTH-1:0] valB,
    output logic             zf_in,
    output logic             of_in,
    output logic             sf_in,
    input  logic [3:0]       dbg_sel,
    output logic [WIDTH-1:0] dbg_val
);

    logic [3:0] src_a;
    logic [3:0] src_b;
    logic [3:0] dst_e;
    logic [3:0] dst_m;

    logic zf_q, zf_d;
    logic sf_q, sf_d;
    logic of_q, of_d;

    // The function code only matters to execute; it is accepted here to keep
    // the fetch bundle intact.
    logic unused_ifun;
    assign unused_ifun = ^ifun;

    // Source / destination decode. Undefined icodes fall to the default and
    // neither read nor write anything.
    always_comb begin
        src_a = RNONE;
        src_b = RNONE;
        dst_e = RNONE;
        dst_m = RNONE;
        case (icode)
            IRRMOVQ: begin
                src_a = rA;
                if (Cnd) begin
                    dst_e = rB;
                end
            end
            IIRMOVQ: begin
                dst_e = rB;
            end
            IRMMOVQ: begin
                src_a = rA;
                src_b = rB;
            end
            IMRMOVQ: begin
                src_b = rB;
                dst_m = rA;
            end
            IOPQ: begin
                src_a = rA;
                src_b = rB;
                dst_e = rB;
            end
            ICALL: begin
                src_b = RSP_ID;
                dst_e = RSP_ID;
            end
            IRET: begin
                src_a = RSP_ID;
                src_b = RSP_ID;
                dst_e = RSP_ID;
            end
            IPUSHQ: begin
                src_a = rA;
                src_b = RSP_ID;
                dst_e = RSP_ID;
            end
            IPOPQ: begin
                src_a = RSP_ID;
                src_b = RSP_ID;
                dst_e = RSP_ID;
                dst_m = rA;
            end
            default: begin
            end
        endcase
    end

    regfile_15x64 #(
        .WIDTH (WIDTH),
        .NREGS (NREGS),
        .RNONE (RNONE)
    ) u_regfile (
        .clk        (clk),
        .rst        (rst),
        .ra_addr_i  (src_a),
        .rb_addr_i  (src_b),
        .dbg_addr_i (dbg_sel),
        .ra_data_o  (valA),
        .rb_data_o  (valB),
        .dbg_data_o (dbg_val),
        .wr_en_i    (~halt),
        .dst_e_i    (dst_e),
        .val_e_i    (valE),
        .dst_m_i    (dst_m),
        .val_m_i    (valM)
    );

    // Condition codes only change on an OPq that is allowed to commit.
    always_comb begin
        zf_d = zf_q;
        sf_d = sf_q;
        of_d = of_q;
        if (!halt && (icode == IOPQ)) begin
            zf_d = zf_out;
            sf_d = sf_out;
            of_d = of_out;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            zf_q <= 1'b1;
            sf_q <= 1'b0;
            of_q <= 1'b0;
        end else begin
            zf_q <= zf_d;
            sf_q <= sf_d;
            of_q <= of_d;
        end
    end

    assign zf_in = zf_q;
    assign sf_in = sf_q;
    assign of_in = of_q;

endmodule
